// File: rtl/word_serializer.sv
// Parallel-in, serial-out word transmitter with valid/ready handshakes on both sides.
// Define WORD_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module word_serializer #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    input  logic             ser_ready,
    output logic             done
);

    // state   | meaning
    // S_IDLE  | waiting for a parallel word, ready=1
    // S_SHIFT | frame in flight, one bit per accepted serial cycle
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int SR_W  = FRAME_LEN;
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [SR_W-1:0]   shreg;
    logic [SR_W-1:0]   load_word;
    logic [SR_W-1:0]   shift_word;
    logic [CNT_W-1:0]  cnt;
    logic              done_q;
    logic              accept;
    logic              hs;
    logic              last_hs;

    assign accept  = (state == S_IDLE) && load;
    assign hs      = (state == S_SHIFT) && ser_ready;
    assign last_hs = hs && (cnt == LAST_CNT);

    // Parity sits on the far end of the register so it always leaves after the data.
    always_comb begin
`ifdef WORD_SERIALIZER_PARITY_EN
        load_word = LSB_FIRST ? {^data_in, data_in} : {data_in, ^data_in};
`else
        load_word = data_in;
`endif
        shift_word = LSB_FIRST ? {1'b0, shreg[SR_W-1:1]} : {shreg[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)  state_nxt = S_SHIFT;
            S_SHIFT: if (last_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (accept) begin
                shreg <= load_word;
                cnt   <= '0;
            end else if (hs) begin
                shreg <= shift_word;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ready     = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_first = 1'b0;
        case (state)
            S_IDLE: ready = 1'b1;
            S_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = LSB_FIRST ? shreg[0] : shreg[SR_W-1];
                ser_first = (cnt == '0);
            end
            default: ready = 1'b1;
        endcase
    end

    assign done = done_q;

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-in, serial-out transmitter: it captures a parallel word such as a 32-bit or 22-bit register value and shifts it out one bit per accepted cycle on a serial link.
- It is the read-out end of the parallel load-register path: a register loads the word in parallel, and this block unloads it bit by bit toward a serial receiver.
- Valid/ready handshake on both the parallel side and the serial side.

Parameters:
- WIDTH, 32, number of data bits per frame (22 is also supported and tested).
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  parallel word to send.
- load  input  1  parallel-side valid; word is accepted when load && ready.
- ready  output  1  block is idle and can accept a word.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a frame bit.
- ser_first  output  1  ser_out is the first bit of the frame.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- done  output  1  one-cycle pulse: frame completely sent.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - ready=1, ser_out=0, ser_valid=0, ser_first=0, done=0.
  - Reset mid-frame aborts the frame; the remaining bits are discarded and no done pulse is issued.
- Shift register and counter:
  - Shift register is WIDTH bits, plus 1 bit when PARITY_EN is defined.
  - bit counter width is $clog2(WIDTH+2).
- IDLE state:
  - ready=1, ser_valid=0, ser_out=0.
  - On load && ready: capture data_in into the shift register, counter=0, go to SHIFT.
  - First bit appears on ser_out the cycle after acceptance (latency 1).
- SHIFT state:
  - ready=0, ser_valid=1.
  - ser_out = shreg[0] when LSB_FIRST=1, shreg[WIDTH-1] otherwise; it is driven directly from the register, with no combinational path from inputs.
  - ser_first=1 only while counter==0.
  - On ser_valid && ser_ready: shift by one toward the output end, counter+1.
  - On ser_ready=0: ser_out, ser_first and the counter hold unchanged (stall for any number of cycles).
  - Handshake of the last frame bit (counter==FRAME_LEN-1): go to IDLE; done=1 in the next cycle, for exactly one cycle.
  - FRAME_LEN = WIDTH, or WIDTH+1 with PARITY_EN.
- load while ready=0 is ignored; data_in is not sampled.
- Back-to-back frames:
  - ready rises in the cycle done pulses.
  - A load in that cycle is accepted, giving a minimum 1-cycle gap (ser_valid=0) between frames.
- data_in may change freely after acceptance without affecting the frame in flight.

Optional Feature:
- Macro: WORD_SERIALIZER_PARITY_EN.
- Defined:
  - Even parity bit P = XOR of all data_in bits, captured at load.
  - P is appended as bit WIDTH+1, always after the data bits regardless of LSB_FIRST.
  - FRAME_LEN = WIDTH+1; done follows the parity bit.
- Undefined: no parity logic, FRAME_LEN = WIDTH.

Test Plan:
- LSB-first basic (WIDTH=32, LSB_FIRST=1, ser_ready=1):
  - Stimulus: load 0xA5A50F0F.
  - Response: ser_out sequence 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1.
  - ser_first high on the first bit only; ser_valid high for exactly 32 cycles; done pulses once, 1 cycle after the last bit; ready=0 throughout the frame.
- MSB-first (LSB_FIRST=0, WIDTH=22):
  - Stimulus: load 22'h200001.
  - Response: first bit 1, then 20 zeros, then 1; done after 22 accepted bits.
- Backpressure:
  - Stimulus: load 0x0000000F, then hold ser_ready=0 for 5 cycles after the 2nd bit.
  - Response: ser_out stays 1 and the counter is frozen during the stall; the full frame is still 1,1,1,1 followed by 28 zeros, with no bit lost or duplicated.
- Busy load ignored:
  - Stimulus: load 0x12345678; assert load with data_in=0xFFFFFFFF mid-frame.
  - Response: the transmitted frame is 0x12345678; the second word is not captured.
  - Stimulus: re-load in the done cycle.
  - Response: the new frame starts after a 1-cycle ser_valid=0 gap.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after bit 10 of 0xFFFFFFFF.
  - Response: ser_valid, ser_out and done go to 0 immediately (asynchronous) and ready=1.
  - After release, a load of 0x00000001 sends 1 then 31 zeros correctly.
- Parity (macro defined, WIDTH=32):
  - Stimulus: load 0x00000001.
  - Response: 33 bits, last bit 1.
  - Stimulus: load 0x00000003.
  - Response: last bit 0; done follows bit 33.
